// File: rtl/uart_cmd_master.sv
// Host-side initiator: sends opcode + 0..4 payload bytes over UART_TX, then gathers 0..8 response bytes.
// Optional stray-byte detection is enabled with `define UART_CMD_STRAY_DETECT_EN.
module uart_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [31:0] cmd_payload,
  input  logic [2:0]  cmd_tx_len,
  input  logic [3:0]  cmd_rx_len,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_data_valid,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic [3:0]  rsp_count,
  output logic        rsp_timeout,
  output logic        stray_flag,
  output logic        busy
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Terminal value is T-2 so the counter lands on T-1 on the same edge that leaves RECV.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, RECV, DONE} state_t;
  state_t state;

  logic [4:0][7:0] tx_bytes;
  logic [7:0][7:0] rsp_bytes;
  logic [7:0]      opcode;
  logic [31:0]     payload;
  logic [2:0]      tx_len;
  logic [2:0]      idx;
  logic [3:0]      rx_len;
  logic [CW-1:0]   tmo_cnt;
  logic            accept;

  assign accept   = cmd_valid & cmd_ready;
  assign tx_bytes = {payload, opcode};
  assign rsp_data = rsp_bytes;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      rsp_valid    <= 1'b0;
      rsp_bytes    <= '0;
      rsp_count    <= 4'd0;
      rsp_timeout  <= 1'b0;
      opcode       <= 8'h00;
      payload      <= 32'h0;
      tx_len       <= 3'd0;
      rx_len       <= 4'd0;
      idx          <= 3'd0;
      tmo_cnt      <= '0;
    end else begin
      uart_tx_en <= 1'b0;
      rsp_valid  <= 1'b0;
      case (state)
        IDLE: begin
          // cmd_ready is held low through the rsp_valid cycle and rises one cycle later.
          cmd_ready <= 1'b1;
          if (accept) begin
            opcode      <= cmd_opcode;
            payload     <= cmd_payload;
            tx_len      <= (cmd_tx_len > 3'd4) ? 3'd4 : cmd_tx_len;
            rx_len      <= (cmd_rx_len > 4'd8) ? 4'd8 : cmd_rx_len;
            idx         <= 3'd0;
            rsp_bytes   <= '0;
            rsp_count   <= 4'd0;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (uart_tx_ready) begin
            uart_tx_data <= tx_bytes[idx];
            uart_tx_en   <= 1'b1;
            state        <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!uart_tx_ready) begin
            idx <= idx + 3'd1;
            if (idx < tx_len) begin
              state <= SEND;
            end else if (rx_len != 4'd0) begin
              tmo_cnt <= '0;
              state   <= RECV;
            end else begin
              state <= DONE;
            end
          end
        end
        RECV: begin
          if (uart_rx_data_valid) begin
            rsp_bytes[rsp_count[2:0]] <= uart_rx_data;
            rsp_count <= rsp_count + 4'd1;
            tmo_cnt   <= '0;
            if ((rsp_count + 4'd1) == rx_len) state <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TO_LAST) begin
              rsp_timeout <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_CMD_STRAY_DETECT_EN
  logic stray_set;
  assign stray_set = uart_rx_data_valid & (state != RECV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           stray_flag <= 1'b0;
    else if (stray_set) stray_flag <= 1'b1;
    else if (accept)    stray_flag <= 1'b0;
  end
`else
  assign stray_flag = 1'b0;
`endif

endmodule
